// File: rtl/ram_io_responder_pkg.sv
// Shared constants for the RAM/I-O responder: I/O window layout, status bits, bus width.
package ram_io_responder_pkg;

    localparam int          BYTE_W      = 8;
    localparam logic [31:0] IO_BASE     = 32'h0003_0000;
    localparam logic [2:0]  IO_OFS_DATA = 3'd0;
    localparam logic [2:0]  IO_OFS_CTRL = 3'd4;

    localparam int STAT_RX_NONEMPTY = 0;
    localparam int STAT_TX_FULL     = 1;
    localparam int STAT_TX_OVF      = 2;

    typedef enum logic [1:0] {
        IO_REG_DATA,
        IO_REG_CTRL,
        IO_REG_NONE
    } io_reg_e;

    function automatic io_reg_e decodeIoReg(input logic [2:0] ofs);
        if (ofs == IO_OFS_DATA) return IO_REG_DATA;
        if (ofs == IO_OFS_CTRL) return IO_REG_CTRL;
        return IO_REG_NONE;
    endfunction

endpackage

// File: rtl/ram_io_responder_sync_fifo.sv
// Byte FIFO used for both UART directions; a pop on a full FIFO frees room for a same-cycle push.
module sync_fifo #(
    parameter int WIDTH      = 8,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic                  pop,
    input  logic [WIDTH-1:0]      din,
    output logic [WIDTH-1:0]      dout,
    output logic                  empty,
    output logic                  full,
    output logic [DEPTH_LOG2:0]   count
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int CNT_W = DEPTH_LOG2 + 1;

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wrPtr_q, rdPtr_q;
    logic [CNT_W-1:0]      count_q;
    logic                  doPush, doPop;

    assign empty  = (count_q == '0);
    assign full   = (count_q == CNT_W'(DEPTH));
    assign doPop  = pop && !empty;
    assign doPush = push && (!full || doPop);
    assign dout   = mem[rdPtr_q];
    assign count  = count_q;

    always_ff @(posedge clk) begin
        if (doPush) mem[wrPtr_q] <= din;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            if (doPush) wrPtr_q <= wrPtr_q + 1'b1;
            if (doPop)  rdPtr_q <= rdPtr_q + 1'b1;
            count_q <= count_q + CNT_W'(doPush) - CNT_W'(doPop);
        end
    end

endmodule

// File: rtl/ram_io_responder.sv
// Far-end responder of the controller's RAM port: byte RAM, I/O window at 0x30000, UART FIFOs.
import ram_io_responder_pkg::*;

module ram_io_responder #(
    parameter int RAM_ADDR_W      = 17,
    parameter int FIFO_DEPTH_LOG2 = 4,
    parameter int FULL_MARGIN     = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              bus_valid,
    input  logic [31:0]       bus_addr,
    input  logic              bus_wr,
    input  logic [BYTE_W-1:0] bus_wdata,
    output logic [BYTE_W-1:0] bus_rdata,
    output logic              io_buffer_full,
    output logic [BYTE_W-1:0] tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    input  logic [BYTE_W-1:0] rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              program_end
);

    localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
    localparam int CNT_W = FIFO_DEPTH_LOG2 + 1;

    logic [BYTE_W-1:0]     mem [1 << RAM_ADDR_W];
    logic [RAM_ADDR_W-1:0] ramIdx;
    logic                  ioSel;
    io_reg_e               ioReg;

    logic [BYTE_W-1:0] rdata_q, ioRdata, status;
    logic              txOverflow_q, txOverflow_d;
    logic              programEnd_q, programEnd_d;
    logic              ioBufferFull_q;

    logic              txPush, txPop, txEmpty, txFull;
    logic [BYTE_W-1:0] txHead;
    logic [CNT_W-1:0]  txCount, txCount_d;
    logic              rxPush, rxPop, rxEmpty, rxFull;
    logic [BYTE_W-1:0] rxHead;
    logic [CNT_W-1:0]  rxCount;
    logic              unusedBits;

    assign ioSel      = (bus_addr[17:16] == IO_BASE[17:16]);
    assign ramIdx     = bus_addr[RAM_ADDR_W-1:0];
    assign ioReg      = decodeIoReg(bus_addr[2:0]);
    assign unusedBits = ^{bus_addr[31:18], rxCount};

    assign txPop  = rdy && tx_ready && !txEmpty;
    assign rxPush = rdy && rx_valid && !rxFull;

    sync_fifo #(.WIDTH(BYTE_W), .DEPTH_LOG2(FIFO_DEPTH_LOG2)) txFifo (
        .clk(clk), .rst(rst), .push(txPush), .pop(txPop), .din(bus_wdata),
        .dout(txHead), .empty(txEmpty), .full(txFull), .count(txCount)
    );

    sync_fifo #(.WIDTH(BYTE_W), .DEPTH_LOG2(FIFO_DEPTH_LOG2)) rxFifo (
        .clk(clk), .rst(rst), .push(rxPush), .pop(rxPop), .din(rx_data),
        .dout(rxHead), .empty(rxEmpty), .full(rxFull), .count(rxCount)
    );

    // I/O register decode; every side effect is gated by rdy so a stalled cycle is inert.
    always_comb begin
        ioRdata      = '0;
        txPush       = 1'b0;
        rxPop        = 1'b0;
        txOverflow_d = txOverflow_q;
        programEnd_d = 1'b0;
        status       = '0;
        status[STAT_RX_NONEMPTY] = !rxEmpty;
        status[STAT_TX_FULL]     = txFull;
        status[STAT_TX_OVF]      = txOverflow_q;
        if (rdy && ioSel) begin
            case (ioReg)
                IO_REG_DATA: begin
                    if (bus_wr) begin
                        if (bus_valid) begin
                            if (txFull) txOverflow_d = 1'b1;
                            else        txPush       = 1'b1;
                        end
                    end else begin
                        ioRdata = rxEmpty ? '0 : rxHead;
                        rxPop   = bus_valid && !rxEmpty;
                    end
                end
                IO_REG_CTRL: begin
                    if (bus_wr) programEnd_d = bus_valid;
                    else        ioRdata      = status;
                end
                default: ioRdata = '0;
            endcase
        end
    end

    // Near-full is computed from the count this edge will produce.
    assign txCount_d = txCount + CNT_W'(txPush) - CNT_W'(txPop);

    always_ff @(posedge clk) begin
        if (rdy && bus_valid && bus_wr && !ioSel) mem[ramIdx] <= bus_wdata;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q        <= '0;
            txOverflow_q   <= 1'b0;
            programEnd_q   <= 1'b0;
            ioBufferFull_q <= 1'b0;
        end else begin
            programEnd_q <= programEnd_d;
            if (rdy) begin
                txOverflow_q   <= txOverflow_d;
                ioBufferFull_q <= ((CNT_W'(DEPTH) - txCount_d) <= CNT_W'(FULL_MARGIN));
                if (!bus_wr) rdata_q <= ioSel ? ioRdata : mem[ramIdx];
            end
        end
    end

    assign bus_rdata      = rdata_q;
    assign io_buffer_full = ioBufferFull_q;
    assign program_end    = programEnd_q;
    assign tx_data        = txHead;
    assign tx_valid       = !txEmpty;
    assign rx_ready       = !rxFull;

endmodule
